// File: rtl/multi_chamber_lock.sv
// Multi-chamber gondola lock: saturating chamber levels, timed per-gate FSMs and gondola tracking.
// Optional macro LOCK_AUTOCLOSE_EN: auto-close a crossed gate and hold it shut until its request drops.
module multi_chamber_lock #(
    parameter int unsigned N_CHAMBERS  = 2,
    parameter int unsigned MAX_LEVEL   = 3,
    parameter int unsigned GATE_CYCLES = 4,
    localparam int unsigned LW = $clog2(MAX_LEVEL + 1),
    localparam int unsigned P  = N_CHAMBERS + 2,
    localparam int unsigned NG = N_CHAMBERS + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CHAMBERS-1:0]    increase,
    input  logic [N_CHAMBERS-1:0]    decrease,
    input  logic [NG-1:0]            gateReq,
    input  logic                     moveR,
    input  logic                     moveL,
    output logic [P-1:0]             gondPos,
    output logic [NG-1:0]            gateClosed,
    output logic [NG-1:0]            gateOpen,
    output logic [N_CHAMBERS*LW-1:0] level,
    output logic                     err
);

    localparam int unsigned CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned PW = $clog2(P);

    typedef enum logic [1:0] {G_CLOSED, G_OPENING, G_OPEN, G_CLOSING} gate_state_e;

    gate_state_e   gst_q [NG];
    gate_state_e   gst_d [NG];
    logic [CW-1:0] cnt_q [NG];
    logic [CW-1:0] cnt_d [NG];
    logic [LW-1:0] lvl_q [N_CHAMBERS];
    logic [LW-1:0] lvl_d [N_CHAMBERS];
    logic [LW-1:0] pos_lvl [P];
    logic [PW-1:0] pos_q, pos_d;
    logic          err_q, err_d;
    logic [P-1:0]  open_r, open_l;
    logic [NG-1:0] force_close, no_reopen;

    // Decoded outputs: gate status, one-hot position, packed levels.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            gateClosed[g] = (gst_q[g] == G_CLOSED);
            gateOpen[g]   = (gst_q[g] == G_OPEN);
        end
        gondPos = P'(1) << pos_q;
        level   = '0;
        for (int c = 0; c < N_CHAMBERS; c++) begin
            level[c*LW +: LW] = lvl_q[c];
        end
        err = err_q;
    end

    // Position levels and whether the gate to the right / left of each position is open.
    always_comb begin
        pos_lvl[0]   = '0;
        pos_lvl[P-1] = LW'(MAX_LEVEL);
        for (int c = 0; c < N_CHAMBERS; c++) begin
            pos_lvl[c+1] = lvl_q[c];
        end
        open_r = {1'b0, gateOpen};
        open_l = {gateOpen, 1'b0};
    end

`ifdef LOCK_AUTOCLOSE_EN
    logic [NG-1:0] cross_q, cross_d, lock_q, lock_d;

    // A crossing forces the gate closed next edge and locks it until the request is seen low.
    always_comb begin
        cross_d = '0;
        if (moveR && !moveL && open_r[pos_q]) begin
            cross_d = gondPos[NG-1:0];
        end else if (moveL && !moveR && open_l[pos_q]) begin
            cross_d = gondPos[P-1:1];
        end
        lock_d = (lock_q & gateReq) | cross_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cross_q <= '0;
            lock_q  <= '0;
        end else begin
            cross_q <= cross_d;
            lock_q  <= lock_d;
        end
    end

    assign force_close = cross_q;
    assign no_reopen   = lock_q;
`else
    assign force_close = '0;
    assign no_reopen   = '0;
`endif

    // Next-state logic for levels, gate FSMs and gondola position.
    always_comb begin
        for (int c = 0; c < N_CHAMBERS; c++) begin
            lvl_d[c] = lvl_q[c];
            if (gst_q[c] == G_CLOSED && gst_q[c+1] == G_CLOSED) begin
                if (increase[c] && !decrease[c] && lvl_q[c] != LW'(MAX_LEVEL)) begin
                    lvl_d[c] = lvl_q[c] + LW'(1);
                end else if (decrease[c] && !increase[c] && lvl_q[c] != '0) begin
                    lvl_d[c] = lvl_q[c] - LW'(1);
                end
            end
        end

        for (int g = 0; g < NG; g++) begin
            gst_d[g] = gst_q[g];
            cnt_d[g] = cnt_q[g];
            case (gst_q[g])
                G_CLOSED: begin
                    if (gateReq[g] && !no_reopen[g] && pos_lvl[g] == pos_lvl[g+1]) begin
                        gst_d[g] = G_OPENING;
                        cnt_d[g] = CW'(GATE_CYCLES - 1);
                    end
                end
                G_OPENING: begin
                    if (!gateReq[g] || force_close[g]) begin
                        gst_d[g] = G_CLOSING;
                        cnt_d[g] = CW'(GATE_CYCLES - 1);
                    end else if (cnt_q[g] == '0) begin
                        gst_d[g] = G_OPEN;
                    end else begin
                        cnt_d[g] = cnt_q[g] - CW'(1);
                    end
                end
                G_OPEN: begin
                    if (!gateReq[g] || force_close[g]) begin
                        gst_d[g] = G_CLOSING;
                        cnt_d[g] = CW'(GATE_CYCLES - 1);
                    end
                end
                G_CLOSING: begin
                    if (cnt_q[g] == '0) begin
                        gst_d[g] = G_CLOSED;
                    end else begin
                        cnt_d[g] = cnt_q[g] - CW'(1);
                    end
                end
                default: gst_d[g] = G_CLOSED;
            endcase
        end

        pos_d = pos_q;
        err_d = 1'b0;
        if (moveR && moveL) begin
            err_d = 1'b1;
        end else if (moveR) begin
            if (open_r[pos_q]) pos_d = pos_q + PW'(1);
            else               err_d = 1'b1;
        end else if (moveL) begin
            if (open_l[pos_q]) pos_d = pos_q - PW'(1);
            else               err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < NG; g++) begin
                gst_q[g] <= G_CLOSED;
                cnt_q[g] <= '0;
            end
            for (int c = 0; c < N_CHAMBERS; c++) begin
                lvl_q[c] <= '0;
            end
            pos_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int g = 0; g < NG; g++) begin
                gst_q[g] <= gst_d[g];
                cnt_q[g] <= cnt_d[g];
            end
            for (int c = 0; c < N_CHAMBERS; c++) begin
                lvl_q[c] <= lvl_d[c];
            end
            pos_q <= pos_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_multi_chamber_lock.sv
// Scoreboard bench for multi_chamber_lock (N=2, MAX=3, GATE_CYCLES=4): driver queues expectations, monitor checks.
module tb_multi_chamber_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] increase, decrease;
    logic [2:0] gateReq;
    logic       moveR, moveL;
    logic [3:0] gondPos;
    logic [2:0] gateClosed, gateOpen;
    logic [3:0] level;
    logic       err;

    multi_chamber_lock #(
        .N_CHAMBERS (2),
        .MAX_LEVEL  (3),
        .GATE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .increase  (increase),
        .decrease  (decrease),
        .gateReq   (gateReq),
        .moveR     (moveR),
        .moveL     (moveL),
        .gondPos   (gondPos),
        .gateClosed(gateClosed),
        .gateOpen  (gateOpen),
        .level     (level),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] nm;
        logic [3:0]  pos;
        logic [2:0]  closed;
        logic [2:0]  open;
        logic [3:0]  lvl;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] e_pos;
    logic [2:0] e_closed, e_open;
    logic [3:0] e_lvl;
    logic       e_err;

    // Queue the expected post-edge state, then advance to just after the next falling edge.
    task automatic tk(input logic [95:0] nm);
        exp_t e;
        e.nm = nm; e.pos = e_pos; e.closed = e_closed; e.open = e_open; e.lvl = e_lvl; e.err = e_err;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({gondPos, gateClosed, gateOpen, level, err} !== {e.pos, e.closed, e.open, e.lvl, e.err}) begin
                failures++;
                $display("FAIL %0s: got pos=%b closed=%b open=%b lvl=%b err=%b, want pos=%b closed=%b open=%b lvl=%b err=%b",
                         e.nm, gondPos, gateClosed, gateOpen, level, err,
                         e.pos, e.closed, e.open, e.lvl, e.err);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b0; increase = '0; decrease = '0; gateReq = '0; moveR = 1'b0; moveL = 1'b0;
        e_pos = 4'b0001; e_closed = 3'b111; e_open = 3'b000; e_lvl = 4'b0000; e_err = 1'b0;
        @(negedge clk); #1;
        tk("rst_hold"); tk("rst_hold");
        reset = 1'b1;
        tk("rst_rel");

        // Gate 0 open, cross, close.
        gateReq = 3'b001; e_closed = 3'b110;
        repeat (4) tk("g0_opening");
        e_open = 3'b001; tk("g0_open");
        moveR = 1'b1; e_pos = 4'b0010; tk("mv_r_g0"); moveR = 1'b0;
        gateReq = 3'b000; e_open = 3'b000;
        repeat (4) tk("g0_closing");
        e_closed = 3'b111; tk("g0_closed");

        // Raise chamber 0 to saturation; unequal levels keep gate 0 shut.
        increase = 2'b01;
        e_lvl = 4'b0001; tk("inc0_1");
        e_lvl = 4'b0010; tk("inc0_2");
        e_lvl = 4'b0011; tk("inc0_3");
        tk("inc0_sat"); tk("inc0_sat");
        increase = 2'b00;
        gateReq = 3'b001; tk("g0_uneq"); tk("g0_uneq"); gateReq = 3'b000;

`ifdef LOCK_AUTOCLOSE_EN
        decrease = 2'b01;
        e_lvl = 4'b0010; tk("dec0_2");
        e_lvl = 4'b0001; tk("dec0_1");
        e_lvl = 4'b0000; tk("dec0_0");
        decrease = 2'b00;
        gateReq = 3'b001; e_closed = 3'b110;
        repeat (4) tk("ac_opening");
        e_open = 3'b001; tk("ac_open");
        moveL = 1'b1; e_pos = 4'b0001; tk("ac_cross"); moveL = 1'b0;
        e_open = 3'b000;
        repeat (4) tk("ac_closing");
        e_closed = 3'b111; tk("ac_closed");
        tk("ac_locked"); tk("ac_locked");
        gateReq = 3'b000; tk("ac_drop");
        gateReq = 3'b001; e_closed = 3'b110; tk("ac_reopen");
        gateReq = 3'b000;
`else
        // Gate 1 blocked by unequal levels, then equalised and opened.
        gateReq = 3'b010; tk("g1_uneq"); tk("g1_uneq"); gateReq = 3'b000;
        increase = 2'b10;
        e_lvl = 4'b0111; tk("inc1_1");
        e_lvl = 4'b1011; tk("inc1_2");
        e_lvl = 4'b1111; tk("inc1_3");
        increase = 2'b00;
        gateReq = 3'b010; e_closed = 3'b101;
        repeat (4) tk("g1_opening");
        e_open = 3'b010; tk("g1_open");
        decrease = 2'b01; tk("dec0_frozen"); decrease = 2'b00;

        // Moves: legal, through closed gate, both requests, back left.
        moveR = 1'b1; e_pos = 4'b0100; tk("mv_r_g1");
        e_err = 1'b1; tk("mv_r_closed"); moveR = 1'b0;
        e_err = 1'b0; tk("err_clr");
        moveR = 1'b1; moveL = 1'b1; e_err = 1'b1; tk("mv_both");
        moveR = 1'b0; moveL = 1'b0; e_err = 1'b0; tk("err_clr2");
        moveL = 1'b1; e_pos = 4'b0010; tk("mv_l_g1");
        e_err = 1'b1; tk("mv_l_closed"); moveL = 1'b0;
        e_err = 1'b0; tk("err_clr3");

        // Close gate 1, then lower chamber 0 to zero while chamber 1 sees both bits.
        gateReq = 3'b000; e_open = 3'b000;
        repeat (4) tk("g1_closing");
        e_closed = 3'b111; tk("g1_closed");
        increase = 2'b10; decrease = 2'b11;
        e_lvl = 4'b1110; tk("dec0_2");
        e_lvl = 4'b1101; tk("dec0_1");
        e_lvl = 4'b1100; tk("dec0_0");
        tk("dec0_sat");
        increase = 2'b00; decrease = 2'b00;
`endif

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
